// File: rtl/alu_writeback_unit.sv
// alu_writeback_unit: ALU retire stage owning the 32x32 register file, branch resolution, overflow exceptions and lw/sw memory requests
module alu_writeback_unit #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instruction,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_flags,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              branch_valid,
  output logic [31:0]       branch_target,
  output logic              exc_valid,
  output logic [31:0]       exc_pc,
  output logic              exc_sticky
);
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RSP} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [32];
  logic [4:0] mem_rt;
  logic [5:0] opcode, funct;
  logic [4:0] rt, rd;
  logic [15:0] imm;
  logic is_r, r_known, is_slt, imm_wr, ovf, is_mem, is_br, taken, accept, rsp_wr, ret_wr;
  logic wen;
  logic [4:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [31:0] target;
  logic unused_bits;
  assign opcode = in_instruction[31:26];
  assign funct = in_instruction[5:0];
  assign rt = in_instruction[20:16];
  assign rd = in_instruction[15:11];
  assign imm = in_instruction[15:0];
  assign unused_bits = ^{in_instruction[25:21], in_instruction[10:6]};
  assign in_ready = state == IDLE;
  assign mem_req_valid = state == MEM_REQ;
  assign accept = in_valid && in_ready;
  assign is_r = opcode == 6'h00;
  assign r_known = is_r && (funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                          6'h26, 6'h27, 6'h2a, 6'h2b});
  assign imm_wr = opcode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};
  assign is_slt = (is_r && (funct == 6'h2a || funct == 6'h2b)) || opcode == 6'h0a || opcode == 6'h0b;
  // Only the trapping adds/subs honour the overflow flag; the unsigned forms wrap silently.
  assign ovf = in_flags[0] && ((is_r && (funct == 6'h20 || funct == 6'h22)) || opcode == 6'h08);
  assign is_mem = opcode == 6'h23 || opcode == 6'h2b;
  assign is_br = opcode == 6'h04 || opcode == 6'h05;
  assign taken = opcode == 6'h04 ? in_flags[2] : !in_flags[2];
  assign target = in_pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  // The two write sources are exclusive: retire writes only in IDLE, load data only in MEM_RSP.
  assign rsp_wr = state == MEM_RSP && mem_rsp_valid;
  assign ret_wr = accept && (r_known || imm_wr) && !ovf;
  assign waddr = rsp_wr ? mem_rt : is_r ? rd : rt;
  assign wdata = rsp_wr ? mem_rsp_data : is_slt ? {{(DATA_W-1){1'b0}}, in_flags[1]} : in_result;
  assign wen = (rsp_wr || ret_wr) && waddr != 5'd0;
  assign rd_data_a = rd_addr_a == 5'd0 ? '0 : (BYPASS && wen && waddr == rd_addr_a) ? wdata : regs[rd_addr_a];
  assign rd_data_b = rd_addr_b == 5'd0 ? '0 : (BYPASS && wen && waddr == rd_addr_b) ? wdata : regs[rd_addr_b];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[waddr] <= wdata;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mem_rt <= '0;
      mem_req_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      branch_valid <= 1'b0;
      branch_target <= '0;
      exc_valid <= 1'b0;
      exc_pc <= '0;
      exc_sticky <= 1'b0;
    end else begin
      branch_valid <= accept && is_br && taken;
      if (accept && is_br && taken) branch_target <= target;
      exc_valid <= accept && ovf;
      if (accept && ovf) begin
        exc_pc <= in_pc;
        exc_sticky <= 1'b1;
      end
      case (state)
        IDLE: if (accept && is_mem) begin
          mem_rt <= rt;
          mem_req_write <= opcode == 6'h2b;
          mem_req_addr <= in_result;
          mem_req_wdata <= in_store_data;
          state <= MEM_REQ;
        end
        MEM_REQ: if (mem_req_ready) state <= mem_req_write ? IDLE : MEM_RSP;
        MEM_RSP: if (mem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_writeback_unit.sv
// tb_alu_writeback_unit: directed self-checking bench for alu_writeback_unit
module tb_alu_writeback_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_instruction = '0, in_result = '0, in_pc = '0, in_store_data = '0;
  logic [2:0] in_flags = '0;
  logic [4:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic mem_req_valid, mem_req_write;
  logic mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic branch_valid, exc_valid, exc_sticky;
  logic [31:0] branch_target, exc_pc;
  int vectors = 0;
  int miscompares = 0;
  alu_writeback_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_result(in_result), .in_flags(in_flags),
    .in_pc(in_pc), .in_store_data(in_store_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_sticky(exc_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_branch_valid", branch_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_sticky", exc_sticky, 0);
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_instruction = rtype(5'd3, 6'h20); in_result = 32'd2; in_flags = 3'b000; rd_addr_a = 5'd3;
    #1 chk("add_bypass", rd_data_a, 32'd2);
    tick();
    in_valid = 1'b0;
    #1 chk("add_commit", rd_data_a, 32'd2);
    in_valid = 1'b1; in_instruction = rtype(5'd4, 6'h20); in_result = 32'd9; in_flags = 3'b001; in_pc = 32'h40; rd_addr_a = 5'd4;
    #1 chk("ovf_no_bypass", rd_data_a, 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ovf_exc_valid", exc_valid, 1);
    chk("ovf_exc_pc", exc_pc, 32'h40);
    chk("ovf_sticky", exc_sticky, 1);
    chk("ovf_no_write", rd_data_a, 32'd0);
    tick();
    chk("ovf_pulse_end", exc_valid, 0);
    chk("ovf_sticky_hold", exc_sticky, 1);
    in_valid = 1'b1; in_instruction = itype(6'h04, 5'd2, 16'd1); in_flags = 3'b100; in_pc = 32'h100;
    tick();
    chk("beq_taken", branch_valid, 1);
    chk("beq_target", branch_target, 32'h108);
    in_instruction = itype(6'h05, 5'd2, 16'd1);
    tick();
    chk("bne_not_taken", branch_valid, 0);
    in_instruction = itype(6'h04, 5'd2, 16'hFFFE); in_pc = 32'h0;
    tick();
    chk("beq_wrap_taken", branch_valid, 1);
    chk("beq_wrap_target", branch_target, 32'hFFFF_FFFC);
    in_instruction = itype(6'h05, 5'd2, 16'h0010); in_flags = 3'b000; in_pc = 32'h200;
    tick();
    chk("bne_taken", branch_valid, 1);
    chk("bne_target", branch_target, 32'h244);
    in_instruction = itype(6'h0a, 5'd5, 16'h1234); in_result = 32'h1234; in_flags = 3'b010;
    tick();
    chk("branch_pulse_end", branch_valid, 0);
    in_instruction = rtype(5'd0, 6'h2b); in_flags = 3'b010;
    tick();
    in_instruction = rtype(5'd6, 6'h21); in_result = 32'h77; in_flags = 3'b001;
    tick();
    chk("addu_no_exc", exc_valid, 0);
    in_instruction = itype(6'h0f, 5'd10, 16'h00AB); in_result = 32'hAB; in_flags = 3'b000;
    tick();
    in_valid = 1'b0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    #1;
    chk("slti_r5", rd_data_a, 32'd1);
    chk("sltu_r0", rd_data_b, 32'd0);
    rd_addr_a = 5'd6; rd_addr_b = 5'd10;
    #1;
    chk("addu_r6", rd_data_a, 32'h77);
    chk("unknown_r10", rd_data_b, 32'd0);
    chk("unknown_no_mem", mem_req_valid, 0);
    in_valid = 1'b1; in_instruction = itype(6'h23, 5'd7, 16'h0); in_result = 32'hFF;
    tick();
    in_instruction = rtype(5'd8, 6'h20); in_result = 32'h55; in_flags = 3'b000; mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_req_in_ready", in_ready, 0);
      chk("lw_req_valid", mem_req_valid, 1);
      chk("lw_req_addr", mem_req_addr, 32'hFF);
      chk("lw_req_write", mem_req_write, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("lw_rsp_req_drop", mem_req_valid, 0);
    chk("lw_rsp_in_ready", in_ready, 0);
    tick();
    chk("lw_rsp_wait", in_ready, 0);
    in_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    #1 chk("lw_rsp_bypass", rd_data_a, 32'hDEAD_BEEF);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("lw_done_ready", in_ready, 1);
    chk("lw_r7", rd_data_a, 32'hDEAD_BEEF);
    chk("lw_blocked_r8", rd_data_b, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11;
    tick();
    mem_rsp_valid = 1'b0;
    #1 chk("stray_rsp_ignored", rd_data_a, 32'hDEAD_BEEF);
    in_valid = 1'b1; in_instruction = itype(6'h2b, 5'd9, 16'h0); in_result = 32'h300; in_store_data = 32'h1234_5678; mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("sw_req_valid", mem_req_valid, 1);
    chk("sw_req_write", mem_req_write, 1);
    chk("sw_req_addr", mem_req_addr, 32'h300);
    chk("sw_req_wdata", mem_req_wdata, 32'h1234_5678);
    tick();
    chk("sw_done_ready", in_ready, 1);
    chk("sw_done_valid", mem_req_valid, 0);
    in_valid = 1'b1; in_result = 32'h200; in_store_data = 32'hCAFE_F00D; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0; rd_addr_a = 5'd7; rd_addr_b = 5'd5;
    #1 chk("sw2_req_valid", mem_req_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_req_valid", mem_req_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_sticky", exc_sticky, 0);
    chk("rst_mid_r7", rd_data_a, 32'd0);
    chk("rst_mid_r5", rd_data_b, 32'd0);
    chk("rst_mid_addr", mem_req_addr, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", mem_req_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
